// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants, fetch-source encoding and PC increment helper
package cpu_defs_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_REDIR,
        SEL_IRQ,
        SEL_EXC
    } pc_sel_e;

    // Low 31 bits wrap on their own; the supervisor bit is never carried into.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - next-PC priority mux for the fetch stage
// Produces next PC, IF/ID flush/hold controls and the interrupt-accept strobe.
module if_next_pc
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic        i_exc,
    input  logic        i_irq,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc4,
    output logic        o_flush,
    output logic        o_hold,
    output logic        o_irq_take
);

    pc_sel_e w_sel;

    assign o_pc4      = pc_plus4(i_pc);
    // Interrupts wait out a redirect so the saved return address is never a squashed fetch.
    assign o_irq_take = i_irq & ~i_pc[31] & ~i_exc & ~i_redirect;

    always_comb begin
        w_sel = SEL_SEQ;
        if (i_exc)
            w_sel = SEL_EXC;
        else if (o_irq_take)
            w_sel = SEL_IRQ;
        else if (i_redirect)
            w_sel = SEL_REDIR;
        else if (i_stall)
            w_sel = SEL_HOLD;
    end

    always_comb begin
        o_next_pc = o_pc4;
        o_flush   = 1'b0;
        o_hold    = 1'b0;
        case (w_sel)
            SEL_EXC: begin
                o_next_pc = EXC_VEC;
                o_flush   = 1'b1;
            end
            SEL_IRQ: begin
                o_next_pc = IRQ_VEC;
                o_flush   = 1'b1;
            end
            SEL_REDIR: begin
                o_next_pc = i_redirect_pc;
                o_flush   = 1'b1;
            end
            SEL_HOLD: begin
                o_next_pc = i_pc;
                o_hold    = 1'b1;
            end
            default: o_next_pc = o_pc4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, ROM address, IF/ID register
// PC[31] is the supervisor bit; interrupts are accepted only while it is clear.
module if_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic        irq,
    output logic        irq_ack,
    output logic [31:0] irq_epc,
    output logic [31:0] pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_irq_ack;
    logic [31:0] r_irq_epc;

    logic [31:0] w_next_pc;
    logic [31:0] w_pc4;
    logic        w_flush;
    logic        w_hold;
    logic        w_irq_take;

    if_next_pc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc (
        .i_pc          (r_pc),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_exc         (exc),
        .i_irq         (irq),
        .o_next_pc     (w_next_pc),
        .o_pc4         (w_pc4),
        .o_flush       (w_flush),
        .o_hold        (w_hold),
        .o_irq_take    (w_irq_take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_ifid_inst  <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_irq_ack    <= 1'b0;
            r_irq_epc    <= 32'h0;
        end else begin
            r_pc      <= w_next_pc;
            r_irq_ack <= w_irq_take;
            // The fetch being dropped is the one the handler must return to.
            if (w_irq_take)
                r_irq_epc <= r_pc;
            if (w_flush) begin
                r_ifid_inst  <= NOP;
                r_ifid_pc4   <= 32'h0;
                r_ifid_valid <= 1'b0;
            end else if (!w_hold) begin
                r_ifid_inst  <= rom_data;
                r_ifid_pc4   <= w_pc4;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    assign rom_addr   = r_pc[30:0];
    assign pc         = r_pc;
    assign ifid_inst  = r_ifid_inst;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;
    assign irq_ack    = r_irq_ack;
    assign irq_epc    = r_irq_epc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc;
    logic        irq;
    logic        irq_ack;
    logic [31:0] irq_epc;
    logic [31:0] pc;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int vectors     = 0;
    int miscompares = 0;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .irq_epc     (irq_epc),
        .pc          (pc),
        .ifid_inst   (ifid_inst),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid)
    );

    always #5 clk = ~clk;

    // ROM model: word 0 holds a jump, every other address returns a tagged pattern.
    assign rom_data = (rom_addr == 31'h0) ? 32'h0800_0003 : ({1'b0, rom_addr} ^ 32'h1234_0000);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic e, input logic i);
        stall = s; redirect = r; redirect_pc = rpc; exc = e; irq = i;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // 1: reset
        repeat (3) step();
        check("rst_pc",       pc,                  32'h8000_0000);
        check("rst_rom_addr", {1'b0, rom_addr},    32'h0);
        check("rst_valid",    {31'b0, ifid_valid}, 32'h0);
        check("rst_ack",      {31'b0, irq_ack},    32'h0);
        check("rst_inst",     ifid_inst,           32'h0);
        check("rst_epc",      irq_epc,             32'h0);

        // 2: first fetch from reset
        reset = 1'b0;
        step();
        check("run_inst",  ifid_inst,           32'h0800_0003);
        check("run_pc4",   ifid_pc4,            32'h8000_0004);
        check("run_pc",    pc,                  32'h8000_0004);
        check("run_valid", {31'b0, ifid_valid}, 32'h1);

        // 3: reach pc=0x10 with a fetched instruction, stall twice, release
        drive(1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
        step();
        check("redir_valid", {31'b0, ifid_valid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("seq_pc",   pc,        32'h0000_0010);
        check("seq_inst", ifid_inst, 32'h1234_000C);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check("stall_pc",    pc,                  32'h0000_0010);
        check("stall_inst",  ifid_inst,           32'h1234_000C);
        check("stall_pc4",   ifid_pc4,            32'h0000_0010);
        check("stall_valid", {31'b0, ifid_valid}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("rel_pc",   pc,        32'h0000_0014);
        check("rel_inst", ifid_inst, 32'h1234_0010);
        check("rel_pc4",  ifid_pc4,  32'h0000_0014);

        // 4: redirect overrides stall
        drive(1'b1, 1'b1, 32'h0000_00CC, 1'b0, 1'b0);
        step();
        check("rds_pc",    pc,                  32'h0000_00CC);
        check("rds_valid", {31'b0, ifid_valid}, 32'h0);
        check("rds_inst",  ifid_inst,           32'h0);
        check("rds_pc4",   ifid_pc4,            32'h0);

        // 5: interrupt in user mode
        drive(1'b0, 1'b1, 32'h0000_003C, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("pre_irq_pc", pc, 32'h0000_0040);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check("irq_pc",    pc,                  32'h8000_0004);
        check("irq_ack",   {31'b0, irq_ack},    32'h1);
        check("irq_epc",   irq_epc,             32'h0000_0040);
        check("irq_valid", {31'b0, ifid_valid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("ack_pulse", {31'b0, irq_ack}, 32'h0);
        check("epc_hold",  irq_epc,          32'h0000_0040);
        check("hnd_pc",    pc,               32'h8000_0008);

        // 5b: irq held in supervisor mode and during redirect is deferred
        drive(1'b0, 1'b1, 32'h8000_0040, 1'b0, 1'b1);
        step();
        check("sup_redir_ack", {31'b0, irq_ack}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check("sup_ack", {31'b0, irq_ack}, 32'h0);
        check("sup_pc",  pc,               32'h8000_0044);
        drive(1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b1);
        step();
        check("usr_redir_ack", {31'b0, irq_ack}, 32'h0);
        check("usr_redir_pc",  pc,               32'h0000_0050);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check("late_ack", {31'b0, irq_ack}, 32'h1);
        check("late_epc", irq_epc,          32'h0000_0050);
        check("late_pc",  pc,               32'h8000_0004);

        // 6: exc beats irq and redirect
        drive(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h0000_0099, 1'b1, 1'b1);
        step();
        check("exc_pc",    pc,                  32'h8000_0008);
        check("exc_ack",   {31'b0, irq_ack},    32'h0);
        check("exc_valid", {31'b0, ifid_valid}, 32'h0);
        check("exc_epc",   irq_epc,             32'h0000_0050);

        // 6b: 31-bit wrap keeps the supervisor bit
        drive(1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("wrap_pc",   pc,        32'h0000_0000);
        check("wrap_pc4",  ifid_pc4,  32'h0000_0000);
        check("wrap_inst", ifid_inst, 32'h6DCB_FFFC);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("swrap_pc", pc, 32'h8000_0000);

        // reset discards a pending acknowledge
        drive(1'b0, 1'b1, 32'h0000_0060, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check("pre_rst_ack", {31'b0, irq_ack}, 32'h1);
        reset = 1'b1;
        step();
        check("mid_rst_ack", {31'b0, irq_ack}, 32'h0);
        check("mid_rst_pc",  pc,               32'h8000_0000);
        check("mid_rst_epc", irq_epc,          32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
